// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: IF (inst) and MEM (data) share one slave port; 0-cycle added latency.
// Backpressure: grant held (locked) until sram_addr_ok; no requests issued while OST_DEPTH are outstanding.
// Optional ARB_RR_EN: round-robin between masters instead of fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int OST_DEPTH = 4,
    parameter int OST_AW    = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam logic [OST_AW:0] DEPTH_C = (OST_AW + 1)'(OST_DEPTH);

    logic [OST_DEPTH-1:0] id_q;
    logic [OST_AW-1:0]    wptr;
    logic [OST_AW-1:0]    rptr;
    logic [OST_AW:0]      count;
    logic                 lock;
    logic                 lock_id;
    logic                 sel;
    logic                 sel_req;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head_id;

`ifdef ARB_RR_EN
    logic                 rr_last;
`endif

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // 0 = inst, 1 = data; an unaccepted grant stays pinned to its owner
    always_comb begin
        sel = data_req;
`ifdef ARB_RR_EN
        if (inst_req && data_req) begin
            sel = ~rr_last;
        end
`endif
        if (lock) begin
            sel = lock_id;
        end
    end

    assign sel_req    = sel ? data_req : inst_req;
    // full depends only on registered count, so sram_data_ok never reaches sram_req
    assign sram_req   = sel_req & ~full;
    assign sram_wr    = sel ? data_wr    : inst_wr;
    assign sram_size  = sel ? data_size  : inst_size;
    assign sram_wstrb = sel ? data_wstrb : inst_wstrb;
    assign sram_addr  = sel ? data_addr  : inst_addr;
    assign sram_wdata = sel ? data_wdata : inst_wdata;

    assign push         = sram_req & sram_addr_ok;
    assign inst_addr_ok = push & ~sel;
    assign data_addr_ok = push &  sel;

    // A response with nothing outstanding is a slave protocol error and is dropped
    assign pop          = sram_data_ok & ~empty;
    assign head_id      = id_q[rptr];
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop &  head_id;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q    <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else begin
            if (push) begin
                id_q[wptr] <= sel;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (sram_req && !sram_addr_ok) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end else if (push) begin
                lock    <= 1'b0;
            end
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last <= 1'b0;
        end else if (push) begin
            rr_last <= sel;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a queue-based reference model.
// Honours ARB_RR_EN the same way as the design.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [3:0]  inst_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        sram_addr_ok = 0, sram_data_ok = 0;
    logic [31:0] sram_rdata = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;

    sram_like_arbiter #(.OST_DEPTH(DEPTH), .OST_AW(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: outstanding owners in accept order, plus the master holding
    // an offered-but-unaccepted grant and the last master served.
    bit q[$];
    bit held;
    bit held_owner;
    bit last_served;
    int max_q;
    int resp_inst, resp_data;

    task automatic new_inst(input logic [31:0] a);
        inst_req   = 1'b1;
        inst_addr  = a;
        inst_wr    = 1'($urandom);
        inst_size  = 2'($urandom);
        inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
    endtask

    task automatic new_data(input logic [31:0] a);
        data_req   = 1'b1;
        data_addr  = a;
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom);
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
    endtask

    // Inputs are set at the negedge; checks 1ns later; model advances on posedge.
    task automatic step();
        bit full, sel, rq, acc, pop, head;
        #1;
        full = (q.size() == DEPTH);
        if (held) sel = held_owner;
`ifdef ARB_RR_EN
        else if (inst_req && data_req) sel = !last_served;
`endif
        else sel = data_req;
        rq   = (sel ? data_req : inst_req) && !full;
        acc  = rq && sram_addr_ok;
        pop  = sram_data_ok && (q.size() != 0);
        head = (q.size() != 0) ? q[0] : 1'b0;

        chk("sram_req", 32'(sram_req), 32'(rq));
        if (rq) begin
            chk("sram_addr",  sram_addr,  sel ? data_addr  : inst_addr);
            chk("sram_wdata", sram_wdata, sel ? data_wdata : inst_wdata);
            chk("sram_ctl", {25'd0, sram_wr, sram_size, sram_wstrb},
                sel ? {25'd0, data_wr, data_size, data_wstrb}
                    : {25'd0, inst_wr, inst_size, inst_wstrb});
        end
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !sel));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(acc &&  sel));
        chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && !head));
        chk("data_data_ok", 32'(data_data_ok), 32'(pop &&  head));
        if (pop) begin
            chk("inst_rdata", inst_rdata, sram_rdata);
            chk("data_rdata", data_rdata, sram_rdata);
            if (head) resp_data++; else resp_inst++;
        end

        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(sel);
            last_served = sel;
        end
        if (q.size() > max_q) max_q = q.size();
        if (rq && !sram_addr_ok) begin
            held = 1'b1;
            held_owner = sel;
        end else if (acc) begin
            held = 1'b0;
        end
        @(negedge clk);
        if (acc && !sel) inst_req = 1'b0;
        if (acc &&  sel) data_req = 1'b0;
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b1;
        #1;
        chk("rst_sram_req", 32'(sram_req), 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        q.delete();
        held = 1'b0;
        last_served = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sram_data_ok = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int p_req, input int p_aok, input int p_dok);
        for (int c = 0; c < cycles; c++) begin
            if (!inst_req && $urandom_range(99) < p_req) new_inst($urandom);
            if (!data_req && $urandom_range(99) < p_req) new_data($urandom);
            sram_addr_ok = ($urandom_range(99) < p_aok);
            sram_data_ok = ($urandom_range(99) < p_dok);
            sram_rdata   = $urandom;
            step();
        end
    endtask

    initial begin
        max_q = 0;
        resp_inst = 0;
        resp_data = 0;
        @(negedge clk);
        do_reset();

        // Single instruction fetch: accept now, response two cycles later
        new_inst(32'h1C00_0000);
        sram_addr_ok = 1'b1;
        step();
        step();
        sram_data_ok = 1'b1;
        sram_rdata = 32'h0280_0000;
        step();

        // Both masters request together
        new_inst(32'h1C00_0004);
        new_data(32'h0000_0100);
        sram_addr_ok = 1'b1;
        step();
        sram_addr_ok = 1'b1;
        step();

        // Stalled inst grant while data arrives
        new_inst(32'h1C00_0008);
        step();
        new_data(32'h0000_0200);
        step();
        step();
        sram_addr_ok = 1'b1;
        step();
        sram_addr_ok = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            sram_data_ok = 1'b1;
            sram_rdata = $urandom;
            step();
        end

        random_phase(400, 60, 60, 50);
        random_phase(300, 80, 90, 8);
        random_phase(300, 50, 20, 60);
        random_phase(200, 90, 70, 90);

        // Reset with transactions outstanding; later responses must be dropped
        random_phase(40, 90, 90, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sram_data_ok = 1'b1;
            step();
        end
        random_phase(300, 60, 60, 50);

        chk("queue_reached_full", 32'(max_q), 32'(DEPTH));
        chk("inst_got_responses", 32'(resp_inst > 0), 32'd1);
        chk("data_got_responses", 32'(resp_data > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
